// File: rtl/laq_pkg.sv
// Shared LAQ entry layout, FSM state encoding and the mod-SIZE age helper.
// Entry fields MSB->LSB are {A, val, addr, V, S, M, rd, tag}.
package laq_pkg;

  localparam int WIDTH_REG  = 5;
  localparam int WIDTH_TAG  = 5;
  localparam int WIDTH_ADDR = 32;
  localparam int WIDTH      = 4;
  localparam int SIZE       = 2 ** WIDTH;
  localparam int WIDTH_DATA = 5 + WIDTH_ADDR + WIDTH_REG + WIDTH_TAG;

  localparam int W_FLAG   = 1;
  localparam int OFF_TAG  = 0;
  localparam int OFF_RD   = OFF_TAG + WIDTH_TAG;
  localparam int OFF_M    = OFF_RD + WIDTH_REG;
  localparam int OFF_S    = OFF_M + W_FLAG;
  localparam int OFF_V    = OFF_S + W_FLAG;
  localparam int OFF_ADDR = OFF_V + W_FLAG;
  localparam int OFF_VAL  = OFF_ADDR + WIDTH_ADDR;
  localparam int OFF_A    = OFF_VAL + W_FLAG;

  typedef logic [WIDTH-1:0]      idx_t;
  typedef logic [WIDTH_ADDR-1:0] addr_t;

  typedef struct packed {
    logic                 a;
    logic                 val;
    addr_t                addr;
    logic                 v;
    logic                 s;
    logic                 m;
    logic [WIDTH_REG-1:0] rd;
    logic [WIDTH_TAG-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Distance from head, wrapping naturally in WIDTH bits.
  function automatic idx_t age_of(input idx_t k, input idx_t head);
    return k - head;
  endfunction

endpackage

// File: rtl/laq_oldest_pick.sv
// Combinational oldest-first selector over the eligibility vector, starting at head.
// Zero latency; no flow control.
module laq_oldest_pick
  import laq_pkg::*;
(
  input  logic [SIZE-1:0] i_elig,
  input  idx_t            i_head,
  output logic            o_found,
  output idx_t            o_idx
);

  idx_t w_k;

  // Scan youngest to oldest so the last hit is the smallest age.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_k     = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      w_k = i_head + idx_t'(i);
      if (i_elig[w_k]) begin
        o_found = 1'b1;
        o_idx   = w_k;
      end
    end
  end

endmodule

// File: rtl/laq_load_issue.sv
// Issues the oldest ready LAQ load to the dcache, writes back rd/tag/data, sets S and pops the head.
// Pick->req 1 cycle, rsp->wb 1 cycle, req held until i_req_rdy; LAQ_LOAD_ISSUE_BYPASS_EN pops a head WB in the WB cycle.
module laq_load_issue
  import laq_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [WIDTH_DATA*SIZE-1:0] i_entries,
  input  logic [WIDTH-1:0]           i_tail,
  input  logic                       i_empty,
  input  logic                       i_overflow,
  output logic                       o_re,
  output logic                       o_weS,
  output logic [WIDTH-1:0]           o_waddrS,
  output logic                       o_req_val,
  output logic [WIDTH_ADDR-1:0]      o_req_addr,
  input  logic                       i_req_rdy,
  input  logic                       i_rsp_val,
  input  logic [WIDTH_ADDR-1:0]      i_rsp_data,
  output logic                       o_wb_val,
  output logic [WIDTH_REG-1:0]       o_wb_rd,
  output logic [WIDTH_TAG-1:0]       o_wb_tag,
  output logic [WIDTH_ADDR-1:0]      o_wb_data
);

  entry_t          w_ent [SIZE];
  logic [SIZE-1:0] w_inrange;
  logic [SIZE-1:0] w_elig;
  idx_t            w_occ;
  idx_t            w_pick;
  logic            w_found;
  logic            w_busy;
  logic            w_wb_head;
  logic            w_head_s;
  logic            w_pop;
  state_t          w_state_nxt;

  state_t          r_state;
  idx_t            r_head;
  idx_t            r_idx;
  addr_t           r_addr;
  addr_t           r_data;
  logic            r_killed;

  always_comb begin
    for (int k = 0; k < SIZE; k++) begin
      w_ent[k]      = '0;
      w_ent[k].val  = i_entries[k*WIDTH_DATA + OFF_VAL];
      w_ent[k].addr = i_entries[k*WIDTH_DATA + OFF_ADDR +: WIDTH_ADDR];
      w_ent[k].v    = i_entries[k*WIDTH_DATA + OFF_V];
      w_ent[k].s    = i_entries[k*WIDTH_DATA + OFF_S];
      w_ent[k].m    = i_entries[k*WIDTH_DATA + OFF_M];
      w_ent[k].rd   = i_entries[k*WIDTH_DATA + OFF_RD +: WIDTH_REG];
      w_ent[k].tag  = i_entries[k*WIDTH_DATA + OFF_TAG +: WIDTH_TAG];
    end
  end

  // A stays set after a pop, so occupancy comes from head/tail only.
  assign w_occ  = age_of(i_tail, r_head);
  assign w_busy = (r_state != ST_IDLE);

  always_comb begin
    w_inrange = '0;
    w_elig    = '0;
    for (int k = 0; k < SIZE; k++) begin
      w_inrange[k] = i_overflow | (~i_empty & (age_of(idx_t'(k), r_head) < w_occ));
      w_elig[k]    = w_inrange[k] & w_ent[k].val & w_ent[k].v & ~w_ent[k].s & ~w_ent[k].m
                     & ~(w_busy & (idx_t'(k) == r_idx));
    end
  end

  laq_oldest_pick u_pick (
    .i_elig  (w_elig),
    .i_head  (r_head),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

`ifdef LAQ_LOAD_ISSUE_BYPASS_EN
  assign w_wb_head = (r_state == ST_WB) & ~r_killed & (r_idx == r_head);
`else
  assign w_wb_head = 1'b0;
`endif

  assign w_head_s = w_ent[r_head].s | w_wb_head;
  assign w_pop    = ~i_empty & w_inrange[r_head] & (w_head_s | ~w_ent[r_head].val);
  assign o_re     = w_pop;

  always_comb begin
    w_state_nxt = r_state;
    o_req_val   = 1'b0;
    o_wb_val    = 1'b0;
    o_weS       = 1'b0;
    o_waddrS    = '0;
    o_wb_rd     = '0;
    o_wb_tag    = '0;
    o_wb_data   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        o_req_val = 1'b1;
        if (i_req_rdy) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_rsp_val) w_state_nxt = ST_WB;
      end
      ST_WB: begin
        // A load killed while in flight completes silently.
        if (!r_killed) begin
          o_wb_val  = 1'b1;
          o_weS     = 1'b1;
          o_waddrS  = r_idx;
          o_wb_rd   = w_ent[r_idx].rd;
          o_wb_tag  = w_ent[r_idx].tag;
          o_wb_data = r_data;
        end
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_req_addr = r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_head   <= '0;
      r_idx    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_killed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_head <= r_head + idx_t'(1);
      if (r_state == ST_IDLE && w_found) begin
        r_idx    <= w_pick;
        r_addr   <= w_ent[w_pick].addr;
        r_killed <= 1'b0;
      end
      if ((r_state == ST_REQ || r_state == ST_WAIT) && w_pop && (r_head == r_idx))
        r_killed <= 1'b1;
      if (r_state == ST_WAIT && i_rsp_val) r_data <= i_rsp_data;
    end
  end

endmodule

// File: tb/tb_laq_load_issue.sv
// Bench for laq_load_issue: a behavioural LAQ plus dcache around the DUT, directed scenarios
// and randomized batches checked against an age-order issue list and head-retire count.
module tb_laq_load_issue;

  localparam int WD = 47;
  localparam int N  = 16;

  logic          i_clk;
  logic          i_rst_n;
  logic [WD*N-1:0] i_entries;
  logic [3:0]    i_tail;
  logic          i_empty, i_overflow;
  logic          o_re, o_weS;
  logic [3:0]    o_waddrS;
  logic          o_req_val;
  logic [31:0]   o_req_addr;
  logic          i_req_rdy, i_rsp_val;
  logic [31:0]   i_rsp_data;
  logic          o_wb_val;
  logic [4:0]    o_wb_rd, o_wb_tag;
  logic [31:0]   o_wb_data;

  laq_load_issue dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_entries(i_entries), .i_tail(i_tail),
    .i_empty(i_empty), .i_overflow(i_overflow), .o_re(o_re), .o_weS(o_weS),
    .o_waddrS(o_waddrS), .o_req_val(o_req_val), .o_req_addr(o_req_addr),
    .i_req_rdy(i_req_rdy), .i_rsp_val(i_rsp_val), .i_rsp_data(i_rsp_data),
    .o_wb_val(o_wb_val), .o_wb_rd(o_wb_rd), .o_wb_tag(o_wb_tag), .o_wb_data(o_wb_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural LAQ
  logic        l_a [N], l_val [N], l_v [N], l_s [N], l_m [N];
  logic [31:0] l_addr [N];
  logic [4:0]  l_rd [N], l_tag [N];
  int          l_head, l_count;

  logic        s_re, s_weS, s_req_val, s_wb_val;
  logic [3:0]  s_waddrS;
  logic [31:0] s_req_addr, s_wb_data;
  logic [4:0]  s_wb_rd, s_wb_tag;

  logic [31:0] g_issued [$];

  task automatic drive_laq();
    for (int k = 0; k < N; k++)
      i_entries[k*WD +: WD] = {l_a[k], l_val[k], l_addr[k], l_v[k], l_s[k], l_m[k], l_rd[k], l_tag[k]};
    i_tail     = 4'((l_head + l_count) % N);
    i_empty    = (l_count == 0);
    i_overflow = (l_count == N);
  endtask

  task automatic smp();
    s_re = o_re; s_weS = o_weS; s_waddrS = o_waddrS; s_req_val = o_req_val;
    s_req_addr = o_req_addr; s_wb_val = o_wb_val; s_wb_rd = o_wb_rd;
    s_wb_tag = o_wb_tag; s_wb_data = o_wb_data;
  endtask

  task automatic settle();
    drive_laq();
    #1;
    smp();
  endtask

  // One clock: the LAQ reacts to the strobes it saw before the edge.
  task automatic cyc();
    @(posedge i_clk);
    #1;
    if (s_weS) l_s[s_waddrS] = 1'b1;
    if (s_re) begin
      l_head  = (l_head + 1) % N;
      l_count = l_count - 1;
    end
    drive_laq();
    @(negedge i_clk);
    #1;
    smp();
  endtask

  task automatic push(input logic val, input logic v, input logic m,
                      input logic [31:0] addr, input logic [4:0] rd, input logic [4:0] tag);
    int k;
    k = (l_head + l_count) % N;
    l_a[k] = 1'b1; l_val[k] = val; l_v[k] = v; l_m[k] = m; l_s[k] = 1'b0;
    l_addr[k] = addr; l_rd[k] = rd; l_tag[k] = tag;
    l_count = l_count + 1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      l_a[k] = 0; l_val[k] = 0; l_v[k] = 0; l_s[k] = 0; l_m[k] = 0;
      l_addr[k] = '0; l_rd[k] = '0; l_tag[k] = '0;
    end
    l_head = 0; l_count = 0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i_req_rdy = 1'b0; i_rsp_val = 1'b0; i_rsp_data = '0;
    clear_model();
    drive_laq();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    smp();
  endtask

  task automatic advance_head_to(input int h);
    for (int i = 0; i < 2*N && l_head != h; i++) begin
      push(1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 5'h0);
      settle();
      cyc();
    end
  endtask

  // Reference: eligible loads issue strictly oldest-first; the head retires
  // through killed or eligible entries and stops at the first stuck one.
  task automatic run_engine(input string name, input int budget);
    logic [31:0] e_addr [$];
    logic [4:0]  e_rd [$], e_tag [$], f_rd [$], f_tag [$];
    int          e_idx [$], f_idx [$];
    logic [31:0] f_data [$];
    int exp_total, exp_pops, nreq, nwb, npop, cd, cyc_n;
    logic outstanding, req_seen, blocked, legal;
    logic [31:0] hold_addr;
    exp_pops = 0; blocked = 0; nreq = 0; nwb = 0; npop = 0; cd = 0; cyc_n = 0;
    outstanding = 0; req_seen = 0; hold_addr = '0;
    g_issued.delete();
    for (int i = 0; i < l_count; i++) begin
      int k;
      logic el;
      k  = (l_head + i) % N;
      el = l_val[k] & l_v[k] & ~l_m[k] & ~l_s[k];
      if (el) begin
        e_addr.push_back(l_addr[k]); e_rd.push_back(l_rd[k]);
        e_tag.push_back(l_tag[k]);   e_idx.push_back(k);
      end
      if (!blocked) begin
        if (!l_val[k] || el) exp_pops++;
        else blocked = 1;
      end
    end
    exp_total = e_addr.size();
    while (cyc_n < budget && !(nreq == exp_total && nwb == exp_total && npop == exp_pops)) begin
      i_rsp_val = 1'b0;
      if (outstanding) begin
        if (cd == 0) begin
          i_rsp_val = 1'b1; i_rsp_data = $urandom; f_data.push_back(i_rsp_data); outstanding = 0;
        end else cd--;
      end else if ($urandom_range(0, 9) == 0) begin
        i_rsp_val = 1'b1; i_rsp_data = $urandom;
      end
      i_req_rdy = ($urandom_range(0, 3) != 0);
      if (s_req_val) begin
        n_checks++;
        if (e_addr.size() == 0) begin
          n_err++; $display("FAIL %s extra_req addr=%h required none", name, s_req_addr);
        end else if (!req_seen) begin
          if (s_req_addr !== e_addr[0]) begin
            n_err++; $display("FAIL %s req_order addr=%h required %h", name, s_req_addr, e_addr[0]);
          end
          req_seen = 1; hold_addr = s_req_addr;
        end else if (s_req_addr !== hold_addr) begin
          n_err++; $display("FAIL %s req_stable addr=%h required %h", name, s_req_addr, hold_addr);
        end
        if (i_req_rdy && e_addr.size() > 0) begin
          g_issued.push_back(e_addr.pop_front());
          f_rd.push_back(e_rd.pop_front()); f_tag.push_back(e_tag.pop_front());
          f_idx.push_back(e_idx.pop_front());
          req_seen = 0; outstanding = 1; cd = $urandom_range(0, 3); nreq++;
        end
      end
      n_checks++;
      if (s_wb_val) begin
        if (f_data.size() == 0 || f_rd.size() == 0) begin
          n_err++; $display("FAIL %s extra_wb rd=%0d required none", name, s_wb_rd);
        end else begin
          if (s_wb_rd !== f_rd[0] || s_wb_tag !== f_tag[0] || s_wb_data !== f_data[0] ||
              s_weS !== 1'b1 || s_waddrS !== 4'(f_idx[0])) begin
            n_err++;
            $display("FAIL %s wb rd=%0d tag=%0d data=%h weS=%b waddrS=%0d required rd=%0d tag=%0d data=%h weS=1 waddrS=%0d",
                     name, s_wb_rd, s_wb_tag, s_wb_data, s_weS, s_waddrS, f_rd[0], f_tag[0], f_data[0], f_idx[0]);
          end
          void'(f_rd.pop_front()); void'(f_tag.pop_front());
          void'(f_idx.pop_front()); void'(f_data.pop_front());
          nwb++;
        end
      end else if (s_weS !== 1'b0) begin
        n_err++; $display("FAIL %s weS_without_wb weS=%b required 0", name, s_weS);
      end
      if (s_re) begin
        legal = ~l_val[l_head] | l_s[l_head];
`ifdef LAQ_LOAD_ISSUE_BYPASS_EN
        legal = legal | (s_weS & (s_waddrS == 4'(l_head)));
`endif
        n_checks++;
        if (!legal || l_count == 0) begin
          n_err++; $display("FAIL %s illegal_pop head=%0d count=%0d required no pop", name, l_head, l_count);
        end
        npop++;
      end
      cyc();
      cyc_n++;
    end
    i_req_rdy = 1'b0; i_rsp_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (s_req_val !== 1'b0 || s_re !== 1'b0 || s_wb_val !== 1'b0) begin
        n_err++; $display("FAIL %s quiet req=%b re=%b wb=%b required 0 0 0", name, s_req_val, s_re, s_wb_val);
      end
      cyc();
    end
    n_checks++;
    if (nreq != exp_total || nwb != exp_total || npop != exp_pops) begin
      n_err++;
      $display("FAIL %s totals req=%0d wb=%0d pop=%0d required req=%0d wb=%0d pop=%0d",
               name, nreq, nwb, npop, exp_total, exp_total, exp_pops);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_req_rdy = 1'b0; i_rsp_val = 1'b0; i_rsp_data = '0;
    clear_model();
    drive_laq();
    #2;
    smp();
    n_checks++;
    if ({s_re, s_weS, s_waddrS, s_req_val, s_req_addr, s_wb_val, s_wb_rd, s_wb_tag, s_wb_data} !== '0) begin
      n_err++; $display("FAIL reset_outputs re=%b weS=%b req=%b addr=%h wb=%b required all 0",
                        s_re, s_weS, s_req_val, s_req_addr, s_wb_val);
    end
    do_reset();
    n_checks++;
    if (s_req_val !== 1'b0 || s_re !== 1'b0 || s_wb_val !== 1'b0) begin
      n_err++; $display("FAIL post_reset req=%b re=%b wb=%b required 0", s_req_val, s_re, s_wb_val);
    end
  endtask

  task automatic test_single();
    push(1'b1, 1'b1, 1'b0, 32'h100, 5'd7, 5'd9);
    settle();
    n_checks++;
    if (s_req_val !== 1'b0) begin n_err++; $display("FAIL single_pick_cycle req=%b required 0", s_req_val); end
    cyc();
    n_checks++;
    if (s_req_val !== 1'b1 || s_req_addr !== 32'h100) begin
      n_err++; $display("FAIL single_req req=%b addr=%h required 1 00000100", s_req_val, s_req_addr);
    end
    i_req_rdy = 1'b1;
    cyc();
    i_req_rdy = 1'b0;
    n_checks++;
    if (s_req_val !== 1'b0) begin n_err++; $display("FAIL single_wait req=%b required 0", s_req_val); end
    i_rsp_val = 1'b1; i_rsp_data = 32'hDEAD;
    cyc();
    i_rsp_val = 1'b0;
    n_checks++;
    if (s_wb_val !== 1'b1 || s_wb_data !== 32'hDEAD || s_wb_rd !== 5'd7 || s_wb_tag !== 5'd9 ||
        s_weS !== 1'b1 || s_waddrS !== 4'd0) begin
      n_err++; $display("FAIL single_wb val=%b data=%h rd=%0d tag=%0d weS=%b waddrS=%0d required 1 0000dead 7 9 1 0",
                        s_wb_val, s_wb_data, s_wb_rd, s_wb_tag, s_weS, s_waddrS);
    end
`ifdef LAQ_LOAD_ISSUE_BYPASS_EN
    n_checks++;
    if (s_re !== 1'b1) begin n_err++; $display("FAIL bypass_pop_in_wb re=%b required 1", s_re); end
    cyc();
`else
    n_checks++;
    if (s_re !== 1'b0) begin n_err++; $display("FAIL pop_in_wb re=%b required 0", s_re); end
    cyc();
    n_checks++;
    if (s_re !== 1'b1) begin n_err++; $display("FAIL pop_after_wb re=%b required 1", s_re); end
    cyc();
`endif
    n_checks++;
    if (l_head != 1 || s_re !== 1'b0) begin
      n_err++; $display("FAIL single_head head=%0d re=%b required 1 0", l_head, s_re);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    a = 32'h2000_0040;
    push(1'b1, 1'b1, 1'b0, a, 5'd3, 5'd4);
    settle();
    cyc();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (s_req_val !== 1'b1 || s_req_addr !== a) begin
        n_err++; $display("FAIL bp_hold cycle=%0d req=%b addr=%h required 1 %h", i, s_req_val, s_req_addr, a);
      end
      cyc();
    end
    i_req_rdy = 1'b1;
    n_checks++;
    if (s_req_val !== 1'b1 || s_req_addr !== a) begin
      n_err++; $display("FAIL bp_accept req=%b addr=%h required 1 %h", s_req_val, s_req_addr, a);
    end
    cyc();
    i_req_rdy = 1'b0;
    n_checks++;
    if (s_req_val !== 1'b0) begin n_err++; $display("FAIL bp_released req=%b required 0", s_req_val); end
    cyc();
    i_rsp_val = 1'b1; i_rsp_data = 32'h1234_5678;
    cyc();
    i_rsp_val = 1'b0;
    n_checks++;
    if (s_wb_val !== 1'b1 || s_wb_data !== 32'h1234_5678 || s_waddrS !== 4'd1) begin
      n_err++; $display("FAIL bp_wb val=%b data=%h idx=%0d required 1 12345678 1", s_wb_val, s_wb_data, s_waddrS);
    end
    for (int i = 0; i < 4 && l_count != 0; i++) cyc();
    n_checks++;
    if (l_count != 0 || l_head != 2) begin
      n_err++; $display("FAIL bp_retire count=%0d head=%0d required 0 2", l_count, l_head);
    end
  endtask

  task automatic test_killed();
    push(1'b0, 1'b0, 1'b0, 32'hBAD0, 5'd1, 5'd1);
    settle();
    n_checks++;
    if (s_re !== 1'b1 || s_req_val !== 1'b0) begin
      n_err++; $display("FAIL killed_pop re=%b req=%b required 1 0", s_re, s_req_val);
    end
    cyc();
    n_checks++;
    if (s_req_val !== 1'b0 || s_re !== 1'b0 || l_head != 3) begin
      n_err++; $display("FAIL killed_after req=%b re=%b head=%0d required 0 0 3", s_req_val, s_re, l_head);
    end
  endtask

  task automatic test_inflight_kill();
    push(1'b1, 1'b1, 1'b0, 32'h3300, 5'd5, 5'd6);
    settle();
    cyc();
    n_checks++;
    if (s_req_val !== 1'b1) begin n_err++; $display("FAIL ik_req req=%b required 1", s_req_val); end
    l_val[3] = 1'b0;
    settle();
    n_checks++;
    if (s_re !== 1'b1) begin n_err++; $display("FAIL ik_pop re=%b required 1", s_re); end
    cyc();
    n_checks++;
    if (s_req_val !== 1'b1 || s_req_addr !== 32'h3300) begin
      n_err++; $display("FAIL ik_req_kept req=%b addr=%h required 1 00003300", s_req_val, s_req_addr);
    end
    i_req_rdy = 1'b1;
    cyc();
    i_req_rdy = 1'b0;
    i_rsp_val = 1'b1; i_rsp_data = 32'hFACE;
    cyc();
    i_rsp_val = 1'b0;
    n_checks++;
    if (s_wb_val !== 1'b0 || s_weS !== 1'b0) begin
      n_err++; $display("FAIL ik_wb_suppressed wb=%b weS=%b required 0 0", s_wb_val, s_weS);
    end
    cyc();
    n_checks++;
    if (s_req_val !== 1'b0 || s_wb_val !== 1'b0 || l_head != 4) begin
      n_err++; $display("FAIL ik_idle req=%b wb=%b head=%0d required 0 0 4", s_req_val, s_wb_val, l_head);
    end
  endtask

  task automatic test_age_order();
    advance_head_to(14);
    push(1'b1, 1'b0, 1'b0, 32'hE000, 5'd14, 5'd14);
    push(1'b1, 1'b1, 1'b0, 32'hF000, 5'd15, 5'd15);
    push(1'b1, 1'b1, 1'b0, 32'h0A00, 5'd0,  5'd0);
    push(1'b1, 1'b1, 1'b1, 32'h1000, 5'd1,  5'd1);
    settle();
    run_engine("age", 400);
    n_checks++;
    if (g_issued.size() != 2) begin
      n_err++; $display("FAIL age_count issued=%0d required 2", g_issued.size());
    end else if (g_issued[0] !== 32'hF000 || g_issued[1] !== 32'h0A00) begin
      n_err++; $display("FAIL age_order first=%h second=%h required 0000f000 00000a00", g_issued[0], g_issued[1]);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    push(1'b1, 1'b1, 1'b0, 32'h4400, 5'd2, 5'd2);
    settle();
    i_req_rdy = 1'b1;
    cyc();
    cyc();
    i_req_rdy = 1'b0;
    n_checks++;
    if (s_req_val !== 1'b0) begin n_err++; $display("FAIL rw_in_wait req=%b required 0", s_req_val); end
    i_rst_n = 1'b0;
    clear_model();
    drive_laq();
    #1;
    smp();
    n_checks++;
    if ({s_re, s_weS, s_waddrS, s_req_val, s_req_addr, s_wb_val, s_wb_rd, s_wb_tag, s_wb_data} !== '0) begin
      n_err++; $display("FAIL rw_async_reset req=%b addr=%h wb=%b required all 0", s_req_val, s_req_addr, s_wb_val);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_rsp_val = 1'b1; i_rsp_data = 32'hBEEF;
    #1;
    smp();
    cyc();
    i_rsp_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({s_re, s_weS, s_waddrS, s_req_val, s_req_addr, s_wb_val, s_wb_rd, s_wb_tag, s_wb_data} !== '0) begin
        n_err++; $display("FAIL rw_stale_rsp cycle=%0d wb=%b data=%h req=%b required all 0",
                          i, s_wb_val, s_wb_data, s_req_val);
      end
      cyc();
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < N; i++) push(1'b1, 1'b1, 1'b0, 32'h8000_0000 + 32'(i*4), 5'(i), 5'(31 - i));
    settle();
    run_engine("full", 1500);
    n_checks++;
    if (g_issued.size() != N || l_head != 0 || l_count != 0) begin
      n_err++; $display("FAIL full_wrap issued=%0d head=%0d count=%0d required 16 0 0", g_issued.size(), l_head, l_count);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n;
      do_reset();
      advance_head_to($urandom_range(0, N - 1));
      n = $urandom_range(1, N);
      for (int i = 0; i < n; i++)
        push($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0,
             $urandom, 5'($urandom), 5'($urandom));
      settle();
      run_engine("random", 2000);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_killed();
    test_inflight_kill();
    test_age_order();
    test_reset_in_wait();
    test_full();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
